// File: rtl/soc_arb_pkg.sv
// Shared types and AXI4-Lite constants for the SoC request arbiters.
package soc_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      RESP_SLVERR, RESP_DECERR: return 1'b1;
      RESP_OKAY:                return 1'b0;
      default:                  return 1'b0;  // EXOKAY carries no meaning on AXI4-Lite
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or above the
// pointer, wrapping around, as both a one-hot vector and an index.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_oh_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 gnt_valid_o
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] idx;

  // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt_oh_o    = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDX_W'((int'(ptr_i) + i) % N);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o   = 1'b1;
        gnt_idx_o     = idx;
        gnt_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_rr_req_arbiter.sv
// Shares one AXI4-Lite master port between NO_REQ simple requesters with
// round-robin arbitration and a single outstanding transaction.
module axil_rr_req_arbiter
  import soc_arb_pkg::*;
#(
  parameter int NO_REQ         = 2,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                                     ACLKMST_ACLK,
  input  logic                                     ARSTnMS_ACLK,
  input  logic [NO_REQ-1:0]                        req_valid_i,
  output logic [NO_REQ-1:0]                        req_ready_o,
  input  logic [NO_REQ-1:0]                        req_write_i,
  input  logic [NO_REQ-1:0][AXI_ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NO_REQ-1:0][AXI_DATA_WIDTH-1:0]    req_wdata_i,
  input  logic [NO_REQ-1:0][AXI_STRB_WIDTH-1:0]    req_wstrb_i,
  output logic [NO_REQ-1:0]                        rsp_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]                rsp_rdata_o,
  output logic                                     rsp_err_o,
  output logic [AXI_ADDR_WIDTH-1:0]                m_aw_addr_o,
  output logic [2:0]                               m_aw_prot_o,
  output logic                                     m_aw_valid_o,
  input  logic                                     m_aw_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]                m_w_data_o,
  output logic [AXI_STRB_WIDTH-1:0]                m_w_strb_o,
  output logic                                     m_w_valid_o,
  input  logic                                     m_w_ready_i,
  input  logic [1:0]                               m_b_resp_i,
  input  logic                                     m_b_valid_i,
  output logic                                     m_b_ready_o,
  output logic [AXI_ADDR_WIDTH-1:0]                m_ar_addr_o,
  output logic [2:0]                               m_ar_prot_o,
  output logic                                     m_ar_valid_o,
  input  logic                                     m_ar_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0]                m_r_data_i,
  input  logic [1:0]                               m_r_resp_i,
  input  logic                                     m_r_valid_i,
  output logic                                     m_r_ready_o
);

  localparam int IDX_W = $clog2(NO_REQ);

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          gnt_q, gnt_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXI_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                      aw_valid_q, aw_valid_d;
  logic                      w_valid_q, w_valid_d;
  logic                      ar_valid_q, ar_valid_d;
  logic [NO_REQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;

  logic [NO_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;

  rr_pick #(.N(NO_REQ)) u_rr_pick (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .gnt_oh_o    (pick_oh),
    .gnt_idx_o   (pick_idx),
    .gnt_valid_o (pick_valid)
  );

  // Grant is only offered while idle, so the handshake itself is the accept.
  assign req_ready_o  = (state_q == IDLE) ? pick_oh : '0;

  assign m_aw_addr_o  = addr_q;
  assign m_aw_prot_o  = PROT_DEFAULT;
  assign m_aw_valid_o = aw_valid_q;
  assign m_w_data_o   = wdata_q;
  assign m_w_strb_o   = wstrb_q;
  assign m_w_valid_o  = w_valid_q;
  assign m_b_ready_o  = (state_q == WRESP);
  assign m_ar_addr_o  = addr_q;
  assign m_ar_prot_o  = PROT_DEFAULT;
  assign m_ar_valid_o = ar_valid_q;
  assign m_r_ready_o  = (state_q == RDATA);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_err_o    = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    ar_valid_d  = ar_valid_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          ptr_d   = (pick_idx == IDX_W'(NO_REQ - 1)) ? '0 : pick_idx + 1'b1;
          addr_d  = req_addr_i[pick_idx];
          wdata_d = req_wdata_i[pick_idx];
          wstrb_d = req_wstrb_i[pick_idx];
          if (req_write_i[pick_idx]) begin
            state_d    = WADDR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = RADDR;
            ar_valid_d = 1'b1;
          end
        end
      end
      WADDR: begin
        // AW and W retire independently, in either order or together.
        if (m_aw_ready_i) aw_valid_d = 1'b0;
        if (m_w_ready_i)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) state_d = WRESP;
      end
      WRESP: begin
        if (m_b_valid_i) begin
          state_d            = IDLE;
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_err_d          = resp_is_err(m_b_resp_i);
        end
      end
      RADDR: begin
        if (m_ar_ready_i) begin
          ar_valid_d = 1'b0;
          state_d    = RDATA;
        end
      end
      RDATA: begin
        if (m_r_valid_i) begin
          state_d            = IDLE;
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_rdata_d        = m_r_data_i;
          rsp_err_d          = resp_is_err(m_r_resp_i);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge ACLKMST_ACLK or negedge ARSTnMS_ACLK) begin
    if (!ARSTnMS_ACLK) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      ar_valid_q  <= ar_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_axil_rr_req_arbiter.sv
// Randomized bench for axil_rr_req_arbiter: requesters and an AXI4-Lite slave
// are driven from here and checked against a transaction-level model.
module tb_axil_rr_req_arbiter;
  import soc_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]         req_valid, req_ready, req_write, rsp_valid;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [N-1:0][SW-1:0] req_wstrb;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic [AW-1:0]        m_aw_addr, m_ar_addr;
  logic [2:0]           m_aw_prot, m_ar_prot;
  logic                 m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  logic [DW-1:0]        m_w_data, m_r_data;
  logic [SW-1:0]        m_w_strb;
  logic [1:0]           m_b_resp, m_r_resp;
  logic                 m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;

  axil_rr_req_arbiter #(.NO_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .ACLKMST_ACLK(clk), .ARSTnMS_ACLK(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .m_aw_addr_o(m_aw_addr), .m_aw_prot_o(m_aw_prot), .m_aw_valid_o(m_aw_valid), .m_aw_ready_i(m_aw_ready),
    .m_w_data_o(m_w_data), .m_w_strb_o(m_w_strb), .m_w_valid_o(m_w_valid), .m_w_ready_i(m_w_ready),
    .m_b_resp_i(m_b_resp), .m_b_valid_i(m_b_valid), .m_b_ready_o(m_b_ready),
    .m_ar_addr_o(m_ar_addr), .m_ar_prot_o(m_ar_prot), .m_ar_valid_o(m_ar_valid), .m_ar_ready_i(m_ar_ready),
    .m_r_data_i(m_r_data), .m_r_resp_i(m_r_resp), .m_r_valid_i(m_r_valid), .m_r_ready_o(m_r_ready)
  );

  // Reference model: one outstanding transaction, pointer as a plain integer.
  int            ptr_m, cur_m;
  bit            busy_m, cur_wr, aw_done, w_done, ar_done;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [SW-1:0] cur_wstrb;
  logic [N-1:0]  exp_rsp_v, clr_mask, last_rsp_v;
  logic [DW-1:0] exp_rdata;
  bit            exp_err, last_err, prev_aw;
  int            waits[N];
  int            grant_log[$];

  // Stimulus knobs and observation counters.
  bit gen_en, reads_only, b_en;
  int p_req, p_rdy, w_lag, w_lag_cnt;
  int cyc, rsp_cyc, aw_rise_cyc, aw_vcnt, w_vcnt, b_hs_cnt;
  int n_checks, n_pass;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
  endtask

  function automatic logic [1:0] slave_resp(input logic [AW-1:0] a);
    if (a >= 32'h0200_0000) return RESP_DECERR;
    return ($urandom_range(3) == 0) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  task automatic inject(input int i, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[i] = 1'b1; req_write[i] = wr;
    req_addr[i]  = a;    req_wdata[i] = d; req_wstrb[i] = s;
  endtask

  task automatic drive();
    req_valid = req_valid & ~clr_mask;
    clr_mask  = '0;
    if (gen_en)
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && (!reads_only || i < 2) && $urandom_range(99) < p_req)
          inject(i, reads_only ? 1'b0 : 1'($urandom_range(1)),
                 ($urandom_range(3) == 0) ? 32'h0200_0000 + ($urandom & 32'hFFFC)
                                          : ($urandom & 32'h00FF_FFFC),
                 $urandom, SW'($urandom));
    m_aw_ready = $urandom_range(99) < p_rdy;
    m_ar_ready = $urandom_range(99) < p_rdy;
    if (w_lag > 0) begin
      if (aw_done && w_lag_cnt > 0) w_lag_cnt--;
      m_w_ready = aw_done && (w_lag_cnt == 0);
    end else begin
      m_w_ready = $urandom_range(99) < p_rdy;
    end
    m_b_valid = b_en && busy_m && cur_wr && aw_done && w_done && ($urandom_range(99) < p_rdy);
    m_b_resp  = slave_resp(cur_addr);
    m_r_valid = busy_m && !cur_wr && ar_done && ($urandom_range(99) < p_rdy);
    m_r_resp  = slave_resp(cur_addr);
    m_r_data  = $urandom;
  endtask

  task automatic sample_and_model();
    logic [N-1:0] exp_ready;
    int g;
    bit exp_aw, exp_w, exp_b, exp_ar, exp_r;
    exp_ready = '0;
    g = -1;
    if (!busy_m)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_aw = busy_m && cur_wr && !aw_done;
    exp_w  = busy_m && cur_wr && !w_done;
    exp_b  = busy_m && cur_wr && aw_done && w_done;
    exp_ar = busy_m && !cur_wr && !ar_done;
    exp_r  = busy_m && !cur_wr && ar_done;

    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, exp_rsp_v);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", rsp_err, exp_err);
    check("aw_valid", m_aw_valid, exp_aw);
    check("w_valid", m_w_valid, exp_w);
    check("b_ready", m_b_ready, exp_b);
    check("ar_valid", m_ar_valid, exp_ar);
    check("r_ready", m_r_ready, exp_r);
    check("prot", {m_aw_prot, m_ar_prot}, 6'b0);
    if (exp_aw) check("aw_addr", m_aw_addr, cur_addr);
    if (exp_w)  check("w_payload", {m_w_data, m_w_strb}, {cur_wdata, cur_wstrb});
    if (exp_ar) check("ar_addr", m_ar_addr, cur_addr);

    if (rsp_valid != '0) begin
      rsp_cyc = cyc; last_rsp_v = rsp_valid; last_err = rsp_err;
    end
    if (m_aw_valid && !prev_aw) aw_rise_cyc = cyc;
    prev_aw = m_aw_valid;
    aw_vcnt += int'(m_aw_valid);
    w_vcnt  += int'(m_w_valid);

    exp_rsp_v = '0; exp_rdata = '0; exp_err = 1'b0;
    if (g >= 0) begin
      for (int i = 0; i < N; i++)
        if (i != g && req_valid[i]) begin
          waits[i]++;
          check("fairness", 64'(waits[i] <= N - 1), 64'd1);
        end
      waits[g] = 0;
      grant_log.push_back(g);
      clr_mask[g] = 1'b1;
      busy_m = 1'b1; cur_m = g; cur_wr = req_write[g];
      cur_addr = req_addr[g]; cur_wdata = req_wdata[g]; cur_wstrb = req_wstrb[g];
      aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
      w_lag_cnt = w_lag;
      ptr_m = (g + 1) % N;
    end else if (busy_m) begin
      if (exp_b && m_b_valid) begin
        exp_rsp_v[cur_m] = 1'b1; exp_err = m_b_resp[1]; busy_m = 1'b0; b_hs_cnt++;
      end
      if (exp_r && m_r_valid) begin
        exp_rsp_v[cur_m] = 1'b1; exp_rdata = m_r_data; exp_err = m_r_resp[1]; busy_m = 1'b0;
      end
      if (exp_aw && m_aw_ready) aw_done = 1'b1;
      if (exp_w && m_w_ready)   w_done  = 1'b1;
      if (exp_ar && m_ar_ready) ar_done = 1'b1;
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle();
    cyc++;
    drive();
    @(negedge clk);
    sample_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_outs);
    rst_n = 1'b0;
    req_valid = '0; m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_valid = 1'b0;
    m_ar_ready = 1'b0; m_r_valid = 1'b0;
    #1;
    if (check_outs) begin
      check("rst_req_ready", req_ready, '0);
      check("rst_rsp", {rsp_valid, rsp_rdata, rsp_err}, '0);
      check("rst_valids", {m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready}, 5'b0);
      check("rst_aw_addr", m_aw_addr, '0);
      check("rst_ar_addr", m_ar_addr, '0);
      check("rst_w_payload", {m_w_data, m_w_strb}, '0);
    end
    busy_m = 1'b0; ptr_m = 0; aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
    exp_rsp_v = '0; exp_rdata = '0; exp_err = 1'b0; clr_mask = '0; prev_aw = 1'b0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    grant_log.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    gen_en = 1'b0;
    for (int c = 0; c < 300 && (busy_m || req_valid != '0 || exp_rsp_v != '0); c++) cycle();
    check(tag, {busy_m, req_valid}, '0);
  endtask

  initial begin
    int start;
    n_checks = 0; n_pass = 0; cyc = 0;
    gen_en = 1'b0; reads_only = 1'b0; b_en = 1'b1; p_req = 0; p_rdy = 100; w_lag = 0;
    req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    m_b_resp = RESP_OKAY; m_r_resp = RESP_OKAY; m_r_data = '0;
    #2;
    do_reset(1'b1);

    // Zero-wait write from requester 0.
    start = cyc + 1;
    inject(0, 1'b1, 32'h0010_0004, 32'hDEAD_BEEF, 4'hF);
    repeat (5) cycle();
    check("t1_aw_cycle", aw_rise_cyc - start, 1);
    check("t1_rsp_cycle", rsp_cyc - start, 3);
    check("t1_rsp_vec", last_rsp_v, 3'b001);

    // Two continuous readers alternate from pointer 0.
    do_reset(1'b0);
    gen_en = 1'b1; reads_only = 1'b1; p_req = 100;
    for (int c = 0; c < 100 && grant_log.size() < 4; c++) cycle();
    check("t2_grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4; k++)
      check("t2_grant_order", (grant_log.size() > k) ? grant_log[k] : -1, k % 2);
    drain("t2_drain");
    reads_only = 1'b0;

    // Write whose W channel lags AW by three cycles.
    aw_vcnt = 0; w_vcnt = 0; b_hs_cnt = 0; w_lag = 3;
    inject(1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'h5);
    repeat (9) cycle();
    check("t3_aw_cycles", aw_vcnt, 1);
    check("t3_w_cycles", w_vcnt, 4);
    check("t3_b_count", b_hs_cnt, 1);
    w_lag = 0;

    // Read to an unmapped address answered with DECERR.
    rsp_cyc = -1;
    inject(2, 1'b0, 32'h0200_0000, '0, '0);
    for (int c = 0; c < 20 && rsp_cyc < 0; c++) cycle();
    check("t4_err", last_err, 1);
    check("t4_rsp_vec", last_rsp_v, 3'b100);
    repeat (2) cycle();
    check("t4_idle", {m_ar_valid, m_r_ready, m_aw_valid, m_w_valid, m_b_ready}, 5'b0);

    // Reset while waiting for B, then a lone request from requester 1.
    do_reset(1'b0);
    b_en = 1'b0;
    inject(0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hC);
    for (int c = 0; c < 20 && !(busy_m && aw_done && w_done); c++) cycle();
    check("t5_in_wresp", m_b_ready, 1);
    check("t5_ptr_advanced", ptr_m, 1);
    do_reset(1'b1);
    b_en = 1'b1;
    inject(1, 1'b1, 32'h0000_0080, 32'h0BAD_CAFE, 4'h3);
    repeat (6) cycle();
    check("t5_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    check("t5_rsp_vec", last_rsp_v, 3'b010);

    // Random traffic with a randomly stalling slave.
    do_reset(1'b0);
    gen_en = 1'b1; p_req = 30; p_rdy = 60;
    repeat (3000) cycle();
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_rr_req_arbiter.md
Name: axil_rr_req_arbiter

Overview:
- Shares one AXI4-Lite master port of the SoC crossbar between NO_REQ simple requesters, e.g. boot loader, debug access and DMA descriptor fetch.
- Round-robin arbitration; one outstanding transaction at a time.
- Sequences AW/W/B or AR/R, then returns a single-cycle response pulse to the granted requester.
- Instantiated in soc_top ahead of one crossbar slave port.

Parameters:
- NO_REQ, 2, number of requesters (2..8).
- AXI_ADDR_WIDTH, 32, address width (matches crossbar).
- AXI_DATA_WIDTH, 32, data width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, derived, do not override.

Ports:
- ACLKMST_ACLK  in  1  clock.
- ARSTnMS_ACLK  in  1  reset, asynchronous assert, active-low.
- req_valid_i  in  NO_REQ  per-requester request valid.
- req_ready_o  out  NO_REQ  per-requester accept, one-hot.
- req_write_i  in  NO_REQ  1=write, 0=read.
- req_addr_i  in  NO_REQ x AXI_ADDR_WIDTH  address.
- req_wdata_i  in  NO_REQ x AXI_DATA_WIDTH  write data.
- req_wstrb_i  in  NO_REQ x AXI_STRB_WIDTH  write strobes.
- rsp_valid_o  out  NO_REQ  one-cycle response pulse, one-hot.
- rsp_rdata_o  out  AXI_DATA_WIDTH  read data, valid with rsp_valid_o.
- rsp_err_o  out  1  1 when bresp/rresp[1]=1 (SLVERR/DECERR).
- m_aw_addr_o/m_aw_prot_o/m_aw_valid_o  out  AXI_ADDR_WIDTH/3/1;  m_aw_ready_i  in  1.
- m_w_data_o/m_w_strb_o/m_w_valid_o  out  AXI_DATA_WIDTH/AXI_STRB_WIDTH/1;  m_w_ready_i  in  1.
- m_b_resp_i  in  2;  m_b_valid_i  in  1;  m_b_ready_o  out  1.
- m_ar_addr_o/m_ar_prot_o/m_ar_valid_o  out  AXI_ADDR_WIDTH/3/1;  m_ar_ready_i  in  1.
- m_r_data_i  in  AXI_DATA_WIDTH;  m_r_resp_i  in  2;  m_r_valid_i  in  1;  m_r_ready_o  out  1.

Behaviour:
- Reset values:
  - All valid, ready and rsp outputs 0; address, data and strobe registers 0; prot fixed 3'b000.
  - State IDLE; round-robin pointer 0, so requester 0 has highest priority.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA.
- IDLE:
  - req_ready_o is combinational: one-hot grant g = first asserted req_valid_i searching from the pointer upward, with wrap-around.
  - Handshake completes at that clock edge. Command is latched, pointer <= (g+1) mod NO_REQ, next state WADDR (write) or RADDR (read).
- WADDR:
  - m_aw_valid_o and m_w_valid_o are registered high from the first WADDR cycle.
  - Each drops individually after its own handshake. AW-before-W, W-before-AW and same-cycle handshakes are all legal.
  - When both have completed -> WRESP.
- WRESP: m_b_ready_o=1. On m_b_valid_i -> IDLE; next cycle rsp_valid_o[g]=1, rsp_err_o=m_b_resp_i[1], rsp_rdata_o=0.
- RADDR: m_ar_valid_o=1 until m_ar_ready_i, then -> RDATA.
- RDATA: m_r_ready_o=1. On m_r_valid_i -> IDLE; next cycle rsp_valid_o[g]=1, rsp_rdata_o=m_r_data_i, rsp_err_o=m_r_resp_i[1].
- Latency with zero-wait slave: accept at cycle 0, AW/W (or AR) at cycle 1, B (or R) at cycle 2, rsp_valid_o at cycle 3. The next grant can also happen in cycle 3.
- AXI rules:
  - Valid is never withdrawn before ready.
  - Payload stays stable while valid is high.
  - b_ready/r_ready are low outside WRESP/RDATA, so unsolicited B/R beats are not accepted.
- Requesters hold their request until req_ready; the response has no backpressure.
- Fairness: a continuously requesting requester is granted within NO_REQ grants.
- Non-requesting indices are skipped without consuming an arbitration cycle.
- Reset mid-transaction: FSM returns to IDLE and all outputs take reset values. The in-flight response is discarded and the requester must re-issue.
- rsp_err_o and rsp_rdata_o are 0 whenever rsp_valid_o is 0.

Decomposition:
- Package soc_arb_pkg: state enum arb_state_e, localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, PROT_DEFAULT=3'b000.
- Sub-module rr_pick: combinational round-robin one-hot pick from (req vector, pointer) → (grant one-hot, grant index). Reused later by other SoC arbiters.

Test Plan:
1. Single write from req0, addr 0x0010_0004, data 0xDEADBEEF, strb 4'hF, zero-wait slave, bresp OKAY -> AW/W valid in cycle 1, rsp_valid_o=2'b01 in cycle 3, rsp_err_o=0.
2. req0 and req1 both reading continuously, pointer 0 -> grants in order 0,1,0,1. rsp_rdata_o matches slave data 0x11111111/0x22222222 per requester.
3. Write with m_w_ready_i delayed 3 cycles after AW handshake -> m_aw_valid_o drops after cycle 1, m_w_valid_o held stable 4 cycles, exactly one B accepted.
4. Read to unmapped 0x0200_0000 returning rresp=DECERR -> rsp_err_o=1, rsp_rdata_o = slave data, FSM back in IDLE.
5. ARSTnMS_ACLK asserted during WRESP -> all outputs 0 asynchronously. After release, req1 pending is granted first when the pointer had reached 1.
